move_sequencer: RTL and testbench
=================================

# move_sequencer

Turn-order controller for the tic-tac-toe board datapath. It owns the 9-cell board register and arbitrates board writes between player 1 and player 2. It validates each move, then scans the 8 winning lines sequentially and reports the game outcome. It sits between the two player input front-ends and the display and outcome logic.

## Interface
- FIRST_PLAYER, default 1: player who moves first after reset or new_game (1 or 2).
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- new_game  in  1  synchronous restart; same values as reset.
- p1_req  in  1  player 1 move request, level.
- p1_sq  in  4  player 1 square index, 0..8.
- p2_req  in  1  player 2 move request, level.
- p2_sq  in  4  player 2 square index, 0..8.
- ack  out  1  one-cycle pulse: move accepted.
- nak  out  1  one-cycle pulse: move from the player on turn rejected.
- board  out  18  cell i at [2i+1:2i]; 00 empty, 01 P1, 10 P2.
- turn  out  2  01 P1 to move, 10 P2 to move, 00 busy or game over.
- outcome  out  2  00 in progress, 01 P1 win, 10 P2 win, 11 tie.
- done  out  1  high while the game is over.

## Operation
- Reset values, async rst low and also new_game:
  - board = 0, outcome = 00, done = 0, ack = 0, nak = 0.
  - turn = 01 if FIRST_PLAYER = 1, else 10.
  - move count = 0; state = WAIT.
- new_game is honoured in every state and has priority over all requests.
- WAIT state. Only the requester named by the current turn is sampled; the other player's request is ignored silently, with no nak.
  - If that player's sq is 9..15 or the cell is non-empty: nak pulses, state stays WAIT, board is unchanged.
  - Otherwise the player and square are latched and the state goes to APPLY.
- APPLY state:
  - ack = 1 for this cycle only.
  - Write the player code into the cell; move count increments by 1 (4-bit counter, max 9).
  - Line index = 0; go to SCAN.
- SCAN state runs exactly 8 cycles, one per line index 0..7, with no early exit. Line order is fixed:
  - rows {0,1,2}, {3,4,5}, {6,7,8};
  - columns {0,3,6}, {1,4,7}, {2,5,8};
  - diagonals {0,4,8}, {2,4,6}.
  - A sticky win flag is set if all 3 cells equal the mover's code.
  - After index 7, go to DECIDE.
- DECIDE state:
  - If win: outcome = mover's code, go to OVER.
  - Else if move count = 9: outcome = 11, go to OVER.
  - Else: turn = other player, go to WAIT.
  - A win on the 9th move reports a win, not a tie.
- OVER state: done = 1 and turn = 00. All requests are ignored with no ack or nak. The state is left only via new_game or rst.
- turn = 00 throughout APPLY, SCAN, DECIDE and OVER. Requests in these states are ignored.
- A player whose req stays high after ack is not re-served, because the turn has moved to the other player. If the same player is re-offered the turn while still holding req, that is a new request and is evaluated normally.
- Reset mid-SCAN abandons the move. Board and count clear; no ack or outcome is produced afterwards.

## Timing
All outputs are registered. Let cycle t be the WAIT cycle in which a valid request is sampled.
- t+1: APPLY, ack = 1.
- t+2: board shows the new cell; SCAN begins, indices 0..7 in t+2..t+9.
- t+10: DECIDE.
- t+11: turn (or outcome/done) shows the updated value.
- Request-to-next-turn latency is 11 cycles, fixed.
- nak is high at t+1 for a request rejected at t. Back-to-back invalid requests produce a nak every cycle.
- Minimum game length is 5 moves.

## Test plan
- Reset, FIRST_PLAYER = 1. Expect board = 0, turn = 01, outcome = 00, done = 0. Assert p2_req (sq 4) while P1 is on turn → no ack, no nak, board unchanged.
- P1 plays sq 4 → ack at t+1, board[9:8] = 01 at t+2, turn = 10 at t+11. P2 plays sq 4 → nak, board unchanged. P2 plays sq 12 → nak.
- P1 plays 0, 1, 2; P2 plays 3, 4 → after P1's third move, outcome = 01, done = 1, turn = 00. Further requests are ignored.
- Play the full tie sequence P1 0, P2 1, P1 2, P2 4, P1 3, P2 5, P1 7, P2 6, P1 8 → outcome = 11 after move 9.
- Final move completes diagonal 2-4-6 on the 9th move → outcome = P-win, not 11.
- Assert rst at SCAN cycle 3, and separately new_game in OVER → all outputs return to reset values. The next game's first ack arrives 1 cycle after a valid request.

Source files
------------

// File: rtl/move_sequencer.sv
// Turn-order controller for the tic-tac-toe board. It owns the 9-cell board,
// accepts one validated move at a time from the player on turn, scans the 8
// winning lines one per cycle and then reports win, tie or hands over the turn.
module move_sequencer #(
  parameter int unsigned FIRST_PLAYER = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        new_game_i,
  input  logic        p1_req_i,
  input  logic [3:0]  p1_sq_i,
  input  logic        p2_req_i,
  input  logic [3:0]  p2_sq_i,
  output logic        ack_o,
  output logic        nak_o,
  output logic [17:0] board_o,
  output logic [1:0]  turn_o,
  output logic [1:0]  outcome_o,
  output logic        done_o
);

  typedef enum logic [2:0] {
    S_WAIT   = 3'd0,
    S_APPLY  = 3'd1,
    S_SCAN   = 3'd2,
    S_DECIDE = 3'd3,
    S_OVER   = 3'd4
  } state_t;

  localparam logic [1:0] FIRST_CODE = (FIRST_PLAYER == 2) ? 2'b10 : 2'b01;

  state_t      state_q, state_d;
  logic [17:0] board_q, board_d;
  logic [1:0]  turn_q, turn_d;
  logic [1:0]  outcome_q, outcome_d;
  logic        done_q, done_d;
  logic        ack_q, ack_d;
  logic        nak_q, nak_d;
  logic [1:0]  mover_q, mover_d;   // code of the player on turn / making the move
  logic [3:0]  sq_q, sq_d;         // latched square of the accepted move
  logic [3:0]  count_q, count_d;   // moves applied so far, 0..9
  logic [2:0]  line_q, line_d;     // line currently being scanned
  logic        win_q, win_d;       // sticky: mover completed some line

  logic        req_s;
  logic [3:0]  sel_sq_s;
  logic [11:0] line_s;

  // Three cell indices of winning line idx, in the fixed scan order.
  function automatic logic [11:0] line_cells(input logic [2:0] idx);
    case (idx)
      3'd0:    line_cells = {4'd0, 4'd1, 4'd2};
      3'd1:    line_cells = {4'd3, 4'd4, 4'd5};
      3'd2:    line_cells = {4'd6, 4'd7, 4'd8};
      3'd3:    line_cells = {4'd0, 4'd3, 4'd6};
      3'd4:    line_cells = {4'd1, 4'd4, 4'd7};
      3'd5:    line_cells = {4'd2, 4'd5, 4'd8};
      3'd6:    line_cells = {4'd0, 4'd4, 4'd8};
      3'd7:    line_cells = {4'd2, 4'd4, 4'd6};
      default: line_cells = {4'd0, 4'd4, 4'd8};
    endcase
  endfunction

  // Contents of cell idx; out-of-range indices read as empty.
  function automatic logic [1:0] cell_at(input logic [17:0] brd, input logic [3:0] idx);
    cell_at = 2'b00;
    for (int i = 0; i < 9; i++) begin
      if (idx == 4'(i)) begin
        cell_at = brd[2*i +: 2];
      end else begin
        cell_at = cell_at;
      end
    end
  endfunction

  // Select the request of whichever player currently holds the turn.
  always_comb begin
    req_s    = 1'b0;
    sel_sq_s = 4'd0;
    if (mover_q == 2'b10) begin
      req_s    = p2_req_i;
      sel_sq_s = p2_sq_i;
    end else begin
      req_s    = p1_req_i;
      sel_sq_s = p1_sq_i;
    end
  end

  // Next-state and next-output logic for the move sequence.
  always_comb begin
    state_d   = state_q;
    board_d   = board_q;
    turn_d    = turn_q;
    outcome_d = outcome_q;
    done_d    = done_q;
    ack_d     = 1'b0;
    nak_d     = 1'b0;
    mover_d   = mover_q;
    sq_d      = sq_q;
    count_d   = count_q;
    line_d    = line_q;
    win_d     = win_q;
    line_s    = line_cells(line_q);

    if (new_game_i) begin
      state_d   = S_WAIT;
      board_d   = 18'd0;
      turn_d    = FIRST_CODE;
      outcome_d = 2'b00;
      done_d    = 1'b0;
      mover_d   = FIRST_CODE;
      sq_d      = 4'd0;
      count_d   = 4'd0;
      line_d    = 3'd0;
      win_d     = 1'b0;
    end else begin
      case (state_q)
        S_WAIT: begin
          if (req_s) begin
            if ((sel_sq_s > 4'd8) || (cell_at(board_q, sel_sq_s) != 2'b00)) begin
              nak_d = 1'b1;
            end else begin
              sq_d    = sel_sq_s;
              ack_d   = 1'b1;
              turn_d  = 2'b00;
              state_d = S_APPLY;
            end
          end else begin
            state_d = S_WAIT;
          end
        end
        S_APPLY: begin
          for (int i = 0; i < 9; i++) begin
            if (sq_q == 4'(i)) begin
              board_d[2*i +: 2] = mover_q;
            end else begin
              board_d[2*i +: 2] = board_q[2*i +: 2];
            end
          end
          count_d = count_q + 4'd1;
          line_d  = 3'd0;
          win_d   = 1'b0;
          state_d = S_SCAN;
        end
        S_SCAN: begin
          if ((cell_at(board_q, line_s[11:8]) == mover_q) &&
              (cell_at(board_q, line_s[7:4])  == mover_q) &&
              (cell_at(board_q, line_s[3:0])  == mover_q)) begin
            win_d = 1'b1;
          end else begin
            win_d = win_q;
          end
          if (line_q == 3'd7) begin
            state_d = S_DECIDE;
          end else begin
            line_d = line_q + 3'd1;
          end
        end
        S_DECIDE: begin
          if (win_q) begin
            outcome_d = mover_q;
            done_d    = 1'b1;
            state_d   = S_OVER;
          end else if (count_q == 4'd9) begin
            outcome_d = 2'b11;
            done_d    = 1'b1;
            state_d   = S_OVER;
          end else begin
            mover_d = (mover_q == 2'b01) ? 2'b10 : 2'b01;
            turn_d  = mover_d;
            state_d = S_WAIT;
          end
        end
        S_OVER: begin
          state_d = S_OVER;
        end
        default: begin
          state_d = S_WAIT;
        end
      endcase
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_WAIT;
      board_q   <= 18'd0;
      turn_q    <= FIRST_CODE;
      outcome_q <= 2'b00;
      done_q    <= 1'b0;
      ack_q     <= 1'b0;
      nak_q     <= 1'b0;
      mover_q   <= FIRST_CODE;
      sq_q      <= 4'd0;
      count_q   <= 4'd0;
      line_q    <= 3'd0;
      win_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      board_q   <= board_d;
      turn_q    <= turn_d;
      outcome_q <= outcome_d;
      done_q    <= done_d;
      ack_q     <= ack_d;
      nak_q     <= nak_d;
      mover_q   <= mover_d;
      sq_q      <= sq_d;
      count_q   <= count_d;
      line_q    <= line_d;
      win_q     <= win_d;
    end
  end

  assign ack_o     = ack_q;
  assign nak_o     = nak_q;
  assign board_o   = board_q;
  assign turn_o    = turn_q;
  assign outcome_o = outcome_q;
  assign done_o    = done_q;

endmodule

// File: tb/tb_move_sequencer.sv
// Self-checking bench for move_sequencer: directed game scenarios plus random
// games, compared against a game-level model of board, turn and outcome.
module tb_move_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        new_game_i;
  logic        p1_req_i;
  logic [3:0]  p1_sq_i;
  logic        p2_req_i;
  logic [3:0]  p2_sq_i;
  logic        ack_o;
  logic        nak_o;
  logic [17:0] board_o;
  logic [1:0]  turn_o;
  logic [1:0]  outcome_o;
  logic        done_o;

  int checks = 0;
  int errors = 0;

  // Game-level reference model.
  int bm[9];
  int turn_m;
  int cnt_m;
  int outc_m;
  bit done_m;

  move_sequencer #(.FIRST_PLAYER(1)) dut (
    .clk(clk), .rst(rst), .new_game_i(new_game_i),
    .p1_req_i(p1_req_i), .p1_sq_i(p1_sq_i),
    .p2_req_i(p2_req_i), .p2_sq_i(p2_sq_i),
    .ack_o(ack_o), .nak_o(nak_o), .board_o(board_o),
    .turn_o(turn_o), .outcome_o(outcome_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    new_game_i = 1'b0;
    p1_req_i   = 1'b0;
    p1_sq_i    = 4'd0;
    p2_req_i   = 1'b0;
    p2_sq_i    = 4'd0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 9; i++) bm[i] = 0;
    turn_m = 1;
    cnt_m  = 0;
    outc_m = 0;
    done_m = 1'b0;
  endtask

  function automatic logic [17:0] exp_board();
    logic [17:0] b;
    b = 18'd0;
    for (int i = 0; i < 9; i++) b[2*i +: 2] = 2'(bm[i]);
    return b;
  endfunction

  function automatic logic [1:0] exp_turn();
    if (done_m) return 2'b00;
    return (turn_m == 1) ? 2'b01 : 2'b10;
  endfunction

  function automatic bit wins(input int p);
    for (int r = 0; r < 3; r++)
      if (bm[3*r] == p && bm[3*r+1] == p && bm[3*r+2] == p) return 1'b1;
    for (int c = 0; c < 3; c++)
      if (bm[c] == p && bm[c+3] == p && bm[c+6] == p) return 1'b1;
    if (bm[0] == p && bm[4] == p && bm[8] == p) return 1'b1;
    if (bm[2] == p && bm[4] == p && bm[6] == p) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check_state(input string tag);
    chk({tag, ".board"},   32'(board_o),   32'(exp_board()));
    chk({tag, ".turn"},    32'(turn_o),    32'(exp_turn()));
    chk({tag, ".outcome"}, 32'(outcome_o), 32'(outc_m));
    chk({tag, ".done"},    32'(done_o),    32'(done_m));
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b0;
    #2;
    model_reset();
    check_state("rst_async");
    chk("rst_async.ack", 32'(ack_o), 32'd0);
    chk("rst_async.nak", 32'(nak_o), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic do_new_game();
    clear_inputs();
    new_game_i = 1'b1;
    tick();
    new_game_i = 1'b0;
    model_reset();
    check_state("newgame");
    chk("newgame.ack", 32'(ack_o), 32'd0);
    chk("newgame.nak", 32'(nak_o), 32'd0);
  endtask

  // One request cycle; if accepted, follow the move to its result.
  // abort_at >= 0 applies rst in that busy cycle (3 == SCAN line index 3).
  task automatic attempt(input logic r1, input logic [3:0] s1,
                         input logic r2, input logic [3:0] s2,
                         input int abort_at);
    logic       req;
    logic [3:0] sq;
    bit         acc;
    bit         rej;
    req = (turn_m == 1) ? r1 : r2;
    sq  = (turn_m == 1) ? s1 : s2;
    acc = !done_m && req && (sq <= 4'd8) && (bm[sq] == 0);
    rej = !done_m && req && !acc;
    p1_req_i = r1; p1_sq_i = s1;
    p2_req_i = r2; p2_sq_i = s2;
    tick();
    chk("req.ack", 32'(ack_o), 32'(acc));
    chk("req.nak", 32'(nak_o), 32'(rej));
    if (!acc) begin
      check_state("noacc");
    end else begin
      bm[sq] = turn_m;
      cnt_m++;
      chk("apply.turn", 32'(turn_o), 32'd0);
      for (int i = 0; i < 10; i++) begin
        p1_req_i = 1'($urandom_range(0, 1)); p1_sq_i = 4'($urandom_range(0, 15));
        p2_req_i = 1'($urandom_range(0, 1)); p2_sq_i = 4'($urandom_range(0, 15));
        tick();
        if (i == abort_at) begin
          do_reset();
          return;
        end
        if (i == 0) begin
          chk("scan.board", 32'(board_o), 32'(exp_board()));
          chk("scan.ack",   32'(ack_o),   32'd0);
        end
        if (i < 9) begin
          chk("busy.turn", 32'(turn_o), 32'd0);
          chk("busy.nak",  32'(nak_o),  32'd0);
          chk("busy.done", 32'(done_o), 32'd0);
        end
      end
      clear_inputs();
      if (wins(turn_m)) begin
        outc_m = turn_m;
        done_m = 1'b1;
      end else if (cnt_m == 9) begin
        outc_m = 3;
        done_m = 1'b1;
      end else begin
        turn_m = (turn_m == 1) ? 2 : 1;
      end
      check_state("decided");
    end
  endtask

  task automatic play(input int p, input int sq);
    if (p == 1) attempt(1'b1, 4'(sq), 1'b0, 4'd0, -1);
    else        attempt(1'b0, 4'd0, 1'b1, 4'(sq), -1);
  endtask

  initial begin
    clear_inputs();
    rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_state("reset");
    rst = 1'b1;
    tick();

    // Wrong player ignored; P1 plays centre; P2 bad moves nak back-to-back.
    attempt(1'b0, 4'd0, 1'b1, 4'd4, -1);
    play(1, 4);
    play(2, 4);
    play(2, 12);
    play(2, 15);

    // P1 wins the top row; further requests ignored.
    do_new_game();
    play(1, 0); play(2, 3); play(1, 1); play(2, 4); play(1, 2);
    chk("row.outcome", 32'(outcome_o), 32'd1);
    play(2, 8);
    play(1, 8);

    // Full-board tie.
    do_new_game();
    play(1, 0); play(2, 1); play(1, 2); play(2, 4); play(1, 3);
    play(2, 5); play(1, 7); play(2, 6); play(1, 8);
    chk("tie.outcome", 32'(outcome_o), 32'd3);

    // Ninth move completes diagonal 2-4-6: a win, not a tie.
    do_new_game();
    play(1, 1); play(2, 0); play(1, 3); play(2, 5); play(1, 2);
    play(2, 7); play(1, 4); play(2, 8); play(1, 6);
    chk("diag9.outcome", 32'(outcome_o), 32'd1);

    // new_game from OVER, then reset in SCAN line 3; next game acks at once.
    do_new_game();
    play(1, 4);
    attempt(1'b0, 4'd0, 1'b1, 4'd0, 3);
    check_state("after_abort");
    play(1, 8);

    // Random games.
    for (int g = 0; g < 25; g++) begin
      do_new_game();
      for (int k = 0; k < 80 && !done_m; k++) begin
        logic r1, r2;
        logic [3:0] s1, s2;
        r1 = ($urandom_range(0, 3) != 0);
        r2 = ($urandom_range(0, 3) != 0);
        s1 = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 8));
        s2 = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 8));
        attempt(r1, s1, r2, s2, -1);
      end
      attempt(1'b1, 4'($urandom_range(0, 8)), 1'b1, 4'($urandom_range(0, 8)), -1);
    end

    clear_inputs();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
